// File: rtl/store_buffer_if.sv
// MEM-stage / data-memory signal bundle for store_buffer.
// slave is the store buffer side, master is the pipeline + memory side.
interface store_buffer_if #(
  parameter int DW = 32,
  parameter int AW = 32,
  parameter int CW = 3
);
  logic [AW-1:0] malu_out;
  logic [DW-1:0] mqb;
  logic          mwmem;
  logic          mm2reg;
  logic          dm_ready;
  logic [DW-1:0] dmem_out;
  logic [AW-1:0] dm_waddr;
  logic [DW-1:0] dm_wdata;
  logic          dm_we;
  logic [DW-1:0] mem_rdata;
  logic          sb_stall;
  logic [CW-1:0] sb_count;

  modport slave (
    input  malu_out, mqb, mwmem, mm2reg, dm_ready, dmem_out,
    output dm_waddr, dm_wdata, dm_we, mem_rdata, sb_stall, sb_count
  );

  modport master (
    output malu_out, mqb, mwmem, mm2reg, dm_ready, dmem_out,
    input  dm_waddr, dm_wdata, dm_we, mem_rdata, sb_stall, sb_count
  );
endinterface

// File: rtl/store_buffer.sv
// Store buffer between EXE/MEM and data memory: FIFO of pending word stores.
// Macro SB_FWD_EN: defined = forward load hits from the buffer; undefined = stall and drain on a hit.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int DW    = 32,
  parameter int AW    = 32
) (
  input logic            clk,
  input logic            clrn,
  store_buffer_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0] r_valid;
  logic [AW-1:0]    r_addr [DEPTH];
  logic [DW-1:0]    r_data [DEPTH];
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [CW-1:0]    r_count;

  logic          w_any;
  logic [PW-1:0] w_idx;
  logic          w_load;
  logic          w_store;
  logic          w_hit;
  logic          w_nonempty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_stall;
  logic          w_hit_stall;
`ifdef SB_FWD_EN
  logic [PW-1:0] w_sel;
`endif

  // Scan oldest to youngest so the last match found is the youngest entry.
  always_comb begin
    w_any = 1'b0;
    w_idx = r_head;
`ifdef SB_FWD_EN
    w_sel = r_head;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = r_head + PW'(k);
      if (r_valid[w_idx] && (r_addr[w_idx][AW-1:2] == bus.malu_out[AW-1:2])) begin
        w_any = 1'b1;
`ifdef SB_FWD_EN
        w_sel = w_idx;
`endif
      end
    end
  end

  assign w_load     = bus.mm2reg;
  assign w_store    = bus.mwmem & ~bus.mm2reg;
  assign w_hit      = w_load & w_any;
  assign w_nonempty = (r_count != '0);
  assign w_full     = (r_count == CW'(DEPTH));

`ifdef SB_FWD_EN
  assign w_pop         = w_nonempty & bus.dm_ready & ~w_load;
  assign w_hit_stall   = 1'b0;
  assign bus.mem_rdata = w_hit ? r_data[w_sel] : bus.dmem_out;
`else
  // A hit holds the load and takes the write port until the word is in memory.
  assign w_pop         = w_nonempty & bus.dm_ready & (~w_load | w_hit);
  assign w_hit_stall   = w_hit;
  assign bus.mem_rdata = bus.dmem_out;
`endif

  assign w_stall = (w_full & w_store & ~w_pop) | w_hit_stall;
  assign w_push  = w_store & ~w_stall;

  assign bus.sb_stall = w_stall;
  assign bus.dm_we    = w_pop;
  assign bus.dm_waddr = w_pop ? r_addr[r_head] : '0;
  assign bus.dm_wdata = w_pop ? r_data[r_head] : '0;
  assign bus.sb_count = r_count;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_valid <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      // Clear before set: when full, a same-cycle pop and push share one slot.
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PW'(1);
      end
      if (w_push) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_tail] <= bus.malu_out;
      r_data[r_tail] <= bus.mqb;
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenarios plus random traffic against a queue-based model.
module tb_store_buffer;
  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } ent_t;

  logic clk  = 1'b0;
  logic clrn = 1'b1;
  always #5 clk = ~clk;

  store_buffer_if #(.DW(DW), .AW(AW), .CW(CW)) sb ();
  store_buffer #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (.clk(clk), .clrn(clrn), .bus(sb));

  ent_t        q[$];
  logic [31:0] mem     [logic [29:0]];
  logic [31:0] dut_mem [logic [29:0]];

  int checks = 0;
  int errors = 0;

  logic          obs_we, obs_stall;
  logic [31:0]   obs_waddr, obs_wdata, obs_rd;
  logic [CW-1:0] obs_cnt;
  logic          last_estall = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a[31:2])) return mem[a[31:2]];
    return {a[31:2], 2'b00} ^ 32'h5A5A0000;
  endfunction

  // One cycle: drive at negedge, check just after, update model on posedge.
  task automatic step(input logic st, input logic ld, input logic rdy,
                      input logic [31:0] a, input logic [31:0] d);
    logic hit, st_eff, epop, estall, epush;
    logic [31:0] yd, erd;
    int n;
    sb.mwmem = st; sb.mm2reg = ld; sb.dm_ready = rdy;
    sb.malu_out = a; sb.mqb = d; sb.dmem_out = mem_rd(a);
    #1;
    n = q.size();
    hit = 1'b0; yd = '0;
    foreach (q[i]) if (q[i].addr[31:2] == a[31:2]) begin hit = 1'b1; yd = q[i].data; end
    hit = hit && ld;
    st_eff = st && !ld;
`ifdef SB_FWD_EN
    epop   = (n > 0) && rdy && !ld;
    estall = (n == DEPTH) && st_eff && !epop;
    erd    = hit ? yd : sb.dmem_out;
`else
    epop   = (n > 0) && rdy && (!ld || hit);
    estall = hit || ((n == DEPTH) && st_eff && !epop);
    erd    = sb.dmem_out;
`endif
    epush = st_eff && !estall;
    obs_we = sb.dm_we; obs_stall = sb.sb_stall; obs_waddr = sb.dm_waddr;
    obs_wdata = sb.dm_wdata; obs_rd = sb.mem_rdata; obs_cnt = sb.sb_count;
    chk("sb_count", 32'(obs_cnt), 32'(n));
    chk("dm_we", 32'(obs_we), 32'(epop));
    if (epop) begin
      chk("dm_waddr", obs_waddr, q[0].addr);
      chk("dm_wdata", obs_wdata, q[0].data);
    end
    chk("sb_stall", 32'(obs_stall), 32'(estall));
    chk("mem_rdata", obs_rd, erd);
    if (obs_we) dut_mem[obs_waddr[31:2]] = obs_wdata;
    last_estall = estall;
    @(posedge clk);
    if (epop) begin
      mem[q[0].addr[31:2]] = q[0].data;
      void'(q.pop_front());
    end
    if (epush) q.push_back(ent_t'{a, d});
    @(negedge clk);
  endtask

  task automatic nop(input logic rdy);
    step(1'b0, 1'b0, rdy, 32'h0, 32'h0);
  endtask

  initial begin
    logic st, ld, rdy;
    logic [31:0] a, d;
    int maxc;

    // Reset with busy-looking inputs.
    sb.mwmem = 1'b1; sb.mm2reg = 1'b0; sb.dm_ready = 1'b1;
    sb.malu_out = 32'h40; sb.mqb = 32'hFFFF0000; sb.dmem_out = 32'h12345678;
    #1 clrn = 1'b0;
    #1;
    chk("rst_we", 32'(sb.dm_we), 32'h0);
    chk("rst_stall", 32'(sb.sb_stall), 32'h0);
    chk("rst_waddr", sb.dm_waddr, 32'h0);
    chk("rst_wdata", sb.dm_wdata, 32'h0);
    chk("rst_rdata", sb.mem_rdata, 32'h12345678);
    chk("rst_count", 32'(sb.sb_count), 32'h0);
    repeat (2) @(negedge clk);
    clrn = 1'b1;

    // Single store drains on the following cycle.
    step(1'b1, 1'b0, 1'b1, 32'h8, 32'h11111111);
    chk("t1_no_same_cycle_drain", 32'(obs_we), 32'h0);
    nop(1'b1);
    chk("t1_we", 32'(obs_we), 32'h1);
    chk("t1_waddr", obs_waddr, 32'h8);
    chk("t1_wdata", obs_wdata, 32'h11111111);
    chk("t1_cnt1", 32'(obs_cnt), 32'h1);
    nop(1'b1);
    chk("t1_cnt0", 32'(obs_cnt), 32'h0);

    // Fill, stall on full, then simultaneous pop/push.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 32'(i * 4), 32'hA0000000 + 32'(i));
    step(1'b1, 1'b0, 1'b0, 32'h10, 32'hA0000004);
    chk("t2_full_cnt", 32'(obs_cnt), 32'h4);
    chk("t2_full_stall", 32'(obs_stall), 32'h1);
    step(1'b1, 1'b0, 1'b1, 32'h10, 32'hA0000004);
    chk("t2_pp_stall", 32'(obs_stall), 32'h0);
    chk("t2_pp_we", 32'(obs_we), 32'h1);
    chk("t2_pp_waddr", obs_waddr, 32'h0);
    nop(1'b0);
    chk("t2_pp_cnt", 32'(obs_cnt), 32'h4);
    repeat (4) nop(1'b1);

    // Two stores to one word, then load it.
    step(1'b1, 1'b0, 1'b0, 32'h14, 32'hAAAA0000);
    step(1'b1, 1'b0, 1'b0, 32'h14, 32'hBBBB0000);
`ifdef SB_FWD_EN
    step(1'b0, 1'b1, 1'b0, 32'h14, 32'h0);
    chk("t3_fwd_rdata", obs_rd, 32'hBBBB0000);
    chk("t3_fwd_stall", 32'(obs_stall), 32'h0);
    step(1'b0, 1'b1, 1'b1, 32'h14, 32'h0);
    chk("t3_fwd_load_blocks_pop", 32'(obs_we), 32'h0);
    repeat (2) nop(1'b1);
`else
    step(1'b0, 1'b1, 1'b0, 32'h14, 32'h0);
    chk("t3_hit_stall", 32'(obs_stall), 32'h1);
    step(1'b0, 1'b1, 1'b1, 32'h14, 32'h0);
    chk("t3_drain1_stall", 32'(obs_stall), 32'h1);
    chk("t3_drain1_data", obs_wdata, 32'hAAAA0000);
    step(1'b0, 1'b1, 1'b1, 32'h14, 32'h0);
    chk("t3_drain2_stall", 32'(obs_stall), 32'h1);
    chk("t3_drain2_data", obs_wdata, 32'hBBBB0000);
    step(1'b0, 1'b1, 1'b1, 32'h14, 32'h0);
    chk("t3_release_stall", 32'(obs_stall), 32'h0);
    chk("t3_release_rdata", obs_rd, 32'hBBBB0000);
`endif

    // Load miss with a pending entry.
    mem[30'h24 >> 2] = 32'h90000099;
    step(1'b1, 1'b0, 1'b0, 32'h20, 32'h20202020);
    step(1'b0, 1'b1, 1'b1, 32'h24, 32'h0);
    chk("t4_miss_rdata", obs_rd, 32'h90000099);
    chk("t4_miss_stall", 32'(obs_stall), 32'h0);
    chk("t4_miss_we", 32'(obs_we), 32'h0);
    nop(1'b1);

    // Reset mid-cycle discards pending stores.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'h100 + 32'(i * 4), 32'hDEAD0000 + 32'(i));
    sb.mwmem = 1'b0; sb.mm2reg = 1'b0; sb.dm_ready = 1'b1;
    #2 clrn = 1'b0;
    #1;
    chk("t5_rst_cnt", 32'(sb.sb_count), 32'h0);
    chk("t5_rst_we", 32'(sb.dm_we), 32'h0);
    #1 clrn = 1'b1;
    q.delete();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      nop(1'b1);
      chk("t5_no_write_after_rst", 32'(obs_we), 32'h0);
    end

    // Back-to-back stores through the pointer wrap.
    maxc = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 1'b1, 32'(i * 4), 32'hC0DE0000 + 32'(i));
      if (int'(obs_cnt) > maxc) maxc = int'(obs_cnt);
      if (i > 0) chk("t6_wrap_order", obs_waddr, 32'((i - 1) * 4));
    end
    nop(1'b1);
    chk("t6_last_waddr", obs_waddr, 32'h24);
    chk("t6_max_cnt_le1", 32'(maxc <= 1), 32'h1);

    // Random traffic; stalled instructions are re-presented.
    st = 0; ld = 0; a = 0; d = 0;
    for (int c = 0; c < 400; c++) begin
      rdy = ($urandom_range(0, 9) < 6);
      if (!last_estall) begin
        case ($urandom_range(0, 19))
          0,1,2,3,4,5,6,7,8,9: begin st = 1; ld = 0; end
          10,11,12,13,14:      begin st = 0; ld = 1; end
          15:                  begin st = 1; ld = 1; end
          default:             begin st = 0; ld = 0; end
        endcase
        a = 32'($urandom_range(0, 7) * 4) | 32'($urandom_range(0, 3));
        d = $urandom;
      end
      step(st, ld, rdy, a, d);
    end
    last_estall = 1'b0;
    repeat (DEPTH + 2) nop(1'b1);
    chk("final_cnt", 32'(obs_cnt), 32'h0);
    foreach (mem[k]) if (k != (30'h24 >> 2) || dut_mem.exists(k))
      chk("final_mem", dut_mem.exists(k) ? dut_mem[k] : 32'hBADBAD00, mem[k]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Write-side buffer between the EXE/MEM pipeline register and the data memory.
- Accepts word stores from the MEM stage and queues them in a small FIFO.
- Drains one store per cycle to the data memory write port whenever that port is not needed by a load.
- Supplies the MEM stage load result: either forwarded from the youngest matching pending store or taken from data memory read data.

Parameters:
DEPTH, 4, number of pending-store entries; power of two, minimum 2
DW, 32, data width in bits
AW, 32, byte address width in bits; entries match on word address bits [AW-1:2]

Ports:
clk  input  1  clock; all state updates on rising edge
clrn  input  1  asynchronous active-low reset
malu_out  input  AW  MEM-stage byte address (load or store)
mqb  input  DW  MEM-stage store data
mwmem  input  1  MEM-stage instruction is a word store
mm2reg  input  1  MEM-stage instruction is a word load
dm_ready  input  1  data memory accepts a write this cycle
dmem_out  input  DW  data memory read data for address malu_out (combinational)
dm_waddr  output  AW  write address to data memory (head entry address)
dm_wdata  output  DW  write data to data memory (head entry data)
dm_we  output  1  write strobe; high exactly in cycles where the head entry drains
mem_rdata  output  DW  load result to the MEM/WB register
sb_stall  output  1  holds the pipeline (PC, IF/ID, ID/EXE, EXE/MEM) this cycle
sb_count  output  log2(DEPTH)+1  number of valid entries

Behaviour:
- Storage: DEPTH entries {valid, addr, data}; head and tail pointers wrap modulo DEPTH; sb_count runs 0..DEPTH.
- Reset (clrn=0, asynchronous): all valid bits, pointers and sb_count are 0.
  - While in reset: dm_we=0, sb_stall=0, dm_waddr=0, dm_wdata=0, mem_rdata=dmem_out.
  - Reset mid-operation discards pending stores; they are never written.
- pop = (sb_count!=0) and dm_ready and not mm2reg and not load-drain priority (see Optional Feature).
  - On pop: dm_we=1, dm_waddr/dm_wdata = head entry; the entry is invalidated and head advances on the next edge.
- push = mwmem and not sb_stall.
  - On push: {malu_out, mqb} is written at tail and tail advances on the edge.
  - Store latency to memory is at least 1 cycle after push; a pushed entry is never drained in the same cycle it is pushed.
- Simultaneous push and pop: both take effect; sb_count is unchanged.
- Full: sb_stall=1 when sb_count==DEPTH, mwmem=1 and pop=0.
  - The store is not accepted that cycle and is re-presented next cycle, because the pipeline is held.
  - If full and pop=1, the push is accepted.
- Empty: dm_we=0; mem_rdata=dmem_out.
- Load hit: word address of malu_out equals the addr of any valid entry, while mm2reg=1.
  - The youngest matching entry (nearest to tail) has priority.
- mwmem and mm2reg are never both 1; if they are, mwmem is ignored.
- Stores to the same word stay in FIFO order, so memory ends at the youngest value.
- Outputs dm_waddr, dm_wdata, dm_we, mem_rdata and sb_stall are combinational from registered state and current inputs. No extra pipeline latency on the load path.

Optional Feature:
Macro SB_FWD_EN.
- Defined: a load hit returns the youngest matching entry's data on mem_rdata in the same cycle, with no stall. Load misses return dmem_out. pop is blocked while mm2reg=1.
- Undefined: a load hit asserts sb_stall and forces drain priority: pop ignores mm2reg but still requires dm_ready.
  - Stalling and draining continue until no valid entry matches the address.
  - mem_rdata is then dmem_out.
  - A load miss behaves as in the defined case.

Test Plan:
- Reset, then store 0x11111111 to addr 0x8 with dm_ready=1, then a nop → next cycle dm_we=1, dm_waddr=0x8, dm_wdata=0x11111111; sb_count goes 1→0.
- dm_ready=0, five stores to 0x0,0x4,0x8,0xC,0x10 → sb_count=4 after the fourth; fifth cycle sb_stall=1. Set dm_ready=1 → pop of 0x0 and push of 0x10 occur in the same cycle, sb_count stays 4.
- dm_ready=0, stores 0xAAAA0000 then 0xBBBB0000 to 0x14, then load 0x14.
  - SB_FWD_EN defined: mem_rdata=0xBBBB0000, sb_stall=0.
  - SB_FWD_EN undefined: sb_stall=1 until dm_ready=1 and both entries drain, then mem_rdata=dmem_out=0xBBBB0000.
- Entry pending at 0x20, load from 0x24 with dmem_out=0x90000099 → mem_rdata=0x90000099, no stall, dm_we=0 that cycle.
- Three stores queued, clrn pulsed low mid-cycle → sb_count=0 immediately, dm_we=0, no write observed afterwards.
- Pointer wrap: 10 back-to-back stores to 0x0..0x24 with dm_ready=1 and no loads → memory writes appear in order with correct data, and sb_count never exceeds 1.
